// File: rtl/pico_acc_pkg.sv
// Shared types and constants for the pico_acc accumulator block.
package pico_acc_pkg;

  typedef enum logic [3:0] {
    OP_NOP   = 4'd0,
    OP_LOAD  = 4'd1,
    OP_CLEAR = 4'd2,
    OP_INC   = 4'd3,
    OP_DEC   = 4'd4,
    OP_ADD   = 4'd5,
    OP_SUB   = 4'd6,
    OP_AND   = 4'd7,
    OP_OR    = 4'd8,
    OP_XOR   = 4'd9,
    OP_NOT   = 4'd10,
    OP_SHL   = 4'd11,
    OP_SHR   = 4'd12,
    OP_ROL   = 4'd13,
    OP_ROR   = 4'd14,
    OP_MUL   = 4'd15
  } op_e;

  typedef enum logic {
    IDLE = 1'b0,
    MUL  = 1'b1
  } state_e;

  localparam int unsigned FLAG_N = 3;
  localparam int unsigned FLAG_Z = 2;
  localparam int unsigned FLAG_C = 1;
  localparam int unsigned FLAG_V = 0;

  // Place individual flag bits at their architectural positions.
  function automatic logic [3:0] pack_flags(input logic n, input logic z,
                                            input logic c, input logic v);
    logic [3:0] f;
    f         = '0;
    f[FLAG_N] = n;
    f[FLAG_Z] = z;
    f[FLAG_C] = c;
    f[FLAG_V] = v;
    return f;
  endfunction

endpackage

// File: rtl/pico_acc_if.sv
// Command/result port of the accumulator: decode side is master, block is slave.
interface pico_acc_if
  import pico_acc_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) ();
  logic             valid;
  logic             ready;
  op_e              op;
  logic [WIDTH-1:0] operand;
  logic             sin;
  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] acc_hi;
  logic [3:0]       flags;
  logic             done;

  modport master (
    output valid, op, operand, sin,
    input  ready, acc, acc_hi, flags, done
  );

  modport slave (
    input  valid, op, operand, sin,
    output ready, acc, acc_hi, flags, done
  );
endinterface

// File: rtl/pico_alu.sv
// Combinational single-cycle ALU for opcodes NOP..ROR; MUL is handled by the top.
module pico_alu
  import pico_acc_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  op_e              op_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic             sin_i,
  output logic [WIDTH-1:0] res_o,
  output logic             c_o,
  output logic             v_o
);
  localparam int unsigned MSB = WIDTH - 1;

  logic [WIDTH:0] sum, diff, inc, dec;

  // Wide adders expose carry/borrow in the extra top bit.
  always_comb begin
    sum  = {1'b0, a_i} + {1'b0, b_i};
    diff = {1'b0, a_i} - {1'b0, b_i};
    inc  = {1'b0, a_i} + {{WIDTH{1'b0}}, 1'b1};
    dec  = {1'b0, a_i} - {{WIDTH{1'b0}}, 1'b1};
  end

  // Result and carry/overflow selection per opcode.
  always_comb begin
    res_o = a_i;
    c_o   = 1'b0;
    v_o   = 1'b0;
    case (op_i)
      OP_NOP:   res_o = a_i;
      OP_LOAD:  res_o = b_i;
      OP_CLEAR: res_o = '0;
      OP_INC: begin
        res_o = inc[MSB:0];
        c_o   = inc[WIDTH];
        v_o   = ~a_i[MSB] & inc[MSB];
      end
      OP_DEC: begin
        res_o = dec[MSB:0];
        c_o   = dec[WIDTH];
        v_o   = a_i[MSB] & ~dec[MSB];
      end
      OP_ADD: begin
        res_o = sum[MSB:0];
        c_o   = sum[WIDTH];
        v_o   = (a_i[MSB] == b_i[MSB]) && (sum[MSB] != a_i[MSB]);
      end
      OP_SUB: begin
        res_o = diff[MSB:0];
        c_o   = diff[WIDTH];
        v_o   = (a_i[MSB] != b_i[MSB]) && (diff[MSB] != a_i[MSB]);
      end
      OP_AND:   res_o = a_i & b_i;
      OP_OR:    res_o = a_i | b_i;
      OP_XOR:   res_o = a_i ^ b_i;
      OP_NOT:   res_o = ~a_i;
      OP_SHL: begin
        res_o = {a_i[MSB-1:0], sin_i};
        c_o   = a_i[MSB];
      end
      OP_SHR: begin
        res_o = {sin_i, a_i[MSB:1]};
        c_o   = a_i[0];
      end
      OP_ROL: begin
        res_o = {a_i[MSB-1:0], a_i[MSB]};
        c_o   = a_i[MSB];
      end
      OP_ROR: begin
        res_o = {a_i[0], a_i[MSB:1]};
        c_o   = a_i[0];
      end
      OP_MUL:   res_o = a_i;
    endcase
  end
endmodule

// File: rtl/pico_acc.sv
// Accumulator datapath: registers, NZCV flags, single-cycle ALU ops and a
// WIDTH-cycle shift-add unsigned multiplier behind a valid/ready command port.
module pico_acc
  import pico_acc_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic      clk,
  input  logic      rst,
  pico_acc_if.slave bus
);
  localparam int unsigned CNT_W = $clog2(WIDTH + 1);

  state_e               state_q;
  logic [WIDTH-1:0]     acc_q, acc_hi_q;
  logic [3:0]           flags_q;
  logic                 done_q;
  logic [CNT_W-1:0]     cnt_q;
  logic [2*WIDTH-1:0]   mcand_q, prod_q, prod_d;
  logic [WIDTH-1:0]     mplier_q;
  logic [WIDTH-1:0]     alu_res;
  logic                 alu_c, alu_v;

  pico_alu #(.WIDTH(WIDTH)) u_alu (
    .op_i  (bus.op),
    .a_i   (acc_q),
    .b_i   (bus.operand),
    .sin_i (bus.sin),
    .res_o (alu_res),
    .c_o   (alu_c),
    .v_o   (alu_v)
  );

  // Multiplicand shifts left and multiplier right each step, so only bit 0
  // of the multiplier is inspected and the counter just tracks iterations.
  always_comb begin
    prod_d = prod_q + (mplier_q[0] ? mcand_q : '0);
  end

  // Command acceptance, multiplier FSM and all architectural registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      acc_q    <= '0;
      acc_hi_q <= '0;
      flags_q  <= '0;
      done_q   <= 1'b0;
      cnt_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      prod_q   <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (bus.valid) begin
            if (bus.op == OP_MUL) begin
              mcand_q  <= {{WIDTH{1'b0}}, acc_q};
              mplier_q <= bus.operand;
              prod_q   <= '0;
              cnt_q    <= '0;
              state_q  <= MUL;
            end else begin
              done_q <= 1'b1;
              if (bus.op != OP_NOP) begin
                acc_q   <= alu_res;
                flags_q <= pack_flags(alu_res[WIDTH-1], alu_res == '0, alu_c, alu_v);
              end
            end
          end
        end
        MUL: begin
          prod_q   <= prod_d;
          mcand_q  <= mcand_q << 1;
          mplier_q <= mplier_q >> 1;
          cnt_q    <= cnt_q + CNT_W'(1);
          if (cnt_q == CNT_W'(WIDTH - 1)) begin
            acc_q    <= prod_d[WIDTH-1:0];
            acc_hi_q <= prod_d[2*WIDTH-1:WIDTH];
            flags_q  <= pack_flags(prod_d[WIDTH-1], prod_d[WIDTH-1:0] == '0,
                                   |prod_d[2*WIDTH-1:WIDTH], 1'b0);
            done_q   <= 1'b1;
            cnt_q    <= '0;
            state_q  <= IDLE;
          end
        end
      endcase
    end
  end

  assign bus.ready  = (state_q == IDLE);
  assign bus.acc    = acc_q;
  assign bus.acc_hi = acc_hi_q;
  assign bus.flags  = flags_q;
  assign bus.done   = done_q;
endmodule

// File: tb/tb_pico_acc.sv
// Directed plus randomized bench for pico_acc (WIDTH=8) with an arithmetic reference model.
module tb_pico_acc;
  import pico_acc_pkg::*;

  localparam int unsigned W    = 8;
  localparam int unsigned MOD  = 1 << W;
  localparam int unsigned HALF = 1 << (W - 1);
  localparam int          MAXS = int'(HALF) - 1;
  localparam int          MINS = -int'(HALF);

  logic clk;
  logic rst;

  pico_acc_if #(.WIDTH(W)) bus ();

  pico_acc #(.WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned n_chk  = 0;
  int unsigned n_pass = 0;
  int unsigned n_fail = 0;

  // Reference model state.
  int unsigned m_acc = 0;
  int unsigned m_hi  = 0;
  logic [3:0]  m_fl  = 4'b0000;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int to_signed(input int unsigned x);
    return (x >= HALF) ? int'(x) - int'(MOD) : int'(x);
  endfunction

  // Architectural effect of one completed command, from plain arithmetic.
  function automatic void model_apply(input op_e op, input int unsigned b, input bit s);
    int unsigned a, r, p;
    int          sa, sb, sr;
    bit          c, v;
    a  = m_acc;
    r  = a;
    c  = 1'b0;
    v  = 1'b0;
    sa = to_signed(a);
    sb = to_signed(b);
    if (op == OP_NOP) return;
    case (op)
      OP_LOAD:  r = b;
      OP_CLEAR: r = 0;
      OP_INC: begin r = (a + 1) % MOD; c = (a + 1) >= MOD; sr = sa + 1; v = sr > MAXS; end
      OP_DEC: begin r = (a + MOD - 1) % MOD; c = (a == 0); sr = sa - 1; v = sr < MINS; end
      OP_ADD: begin r = (a + b) % MOD; c = (a + b) >= MOD; sr = sa + sb; v = (sr > MAXS) || (sr < MINS); end
      OP_SUB: begin r = (a + MOD - b) % MOD; c = a < b; sr = sa - sb; v = (sr > MAXS) || (sr < MINS); end
      OP_AND:   r = a & b;
      OP_OR:    r = a | b;
      OP_XOR:   r = a ^ b;
      OP_NOT:   r = (MOD - 1) - a;
      OP_SHL: begin r = (a * 2 + (s ? 1 : 0)) % MOD; c = a >= HALF; end
      OP_SHR: begin r = a / 2 + (s ? HALF : 0); c = (a % 2) == 1; end
      OP_ROL: begin r = (a * 2) % MOD + a / HALF; c = a >= HALF; end
      OP_ROR: begin r = a / 2 + (a % 2) * HALF; c = (a % 2) == 1; end
      OP_MUL: begin p = a * b; r = p % MOD; m_hi = p / MOD; c = m_hi != 0; end
      default: r = a;
    endcase
    m_acc = r;
    m_fl  = {r >= HALF, r == 0, c, v};
  endfunction

  // Issue one command and check every output once it has completed.
  task automatic do_op(input op_e op, input int unsigned opd, input bit s);
    int unsigned pre_acc, pre_hi, cyc;
    logic [3:0]  pre_fl;
    pre_acc = m_acc;
    pre_hi  = m_hi;
    pre_fl  = m_fl;
    bus.valid   = 1'b1;
    bus.op      = op;
    bus.operand = opd[W-1:0];
    bus.sin     = s;
    model_apply(op, opd, s);
    @(posedge clk); #1;
    if (op == OP_MUL) begin
      // Keep a different command asserted while busy; it must be ignored.
      bus.op      = OP_LOAD;
      bus.operand = 8'h55;
      cyc = 0;
      while (bus.ready !== 1'b1 && cyc < 3 * W) begin
        chk("busy_acc", bus.acc, pre_acc);
        chk("busy_hi", bus.acc_hi, pre_hi);
        chk("busy_flags", bus.flags, pre_fl);
        chk("busy_done", bus.done, 1'b0);
        if (cyc == W - 1) bus.valid = 1'b0;
        @(posedge clk); #1;
        cyc++;
      end
      chk("mul_latency", cyc, W);
    end
    bus.valid = 1'b0;
    chk("acc", bus.acc, m_acc);
    chk("acc_hi", bus.acc_hi, m_hi);
    chk("flags", bus.flags, m_fl);
    chk("done", bus.done, 1'b1);
    chk("ready", bus.ready, 1'b1);
  endtask

  task automatic idle_cycle();
    bus.valid = 1'b0;
    @(posedge clk); #1;
    chk("idle_done", bus.done, 1'b0);
    chk("idle_acc", bus.acc, m_acc);
    chk("idle_ready", bus.ready, 1'b1);
  endtask

  // Asynchronous reset pulse between clock edges.
  task automatic async_reset();
    rst = 1'b1;
    #2;
    chk("rst_acc", bus.acc, 0);
    chk("rst_hi", bus.acc_hi, 0);
    chk("rst_flags", bus.flags, 4'b0000);
    chk("rst_ready", bus.ready, 1'b1);
    chk("rst_done", bus.done, 1'b0);
    m_acc = 0;
    m_hi  = 0;
    m_fl  = 4'b0000;
    #2;
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  initial begin
    op_e         rop;
    int unsigned ropd;
    rst         = 1'b1;
    bus.valid   = 1'b0;
    bus.op      = OP_NOP;
    bus.operand = '0;
    bus.sin     = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("init_acc", bus.acc, 0);
    chk("init_flags", bus.flags, 4'b0000);
    chk("init_ready", bus.ready, 1'b1);
    chk("init_done", bus.done, 1'b0);
    rst = 1'b0;
    @(posedge clk); #1;

    // Wrap-around increment / decrement.
    do_op(OP_LOAD, 8'hFF, 1'b0);
    do_op(OP_INC, 0, 1'b0);
    chk("inc_wrap_acc", bus.acc, 8'h00);
    chk("inc_wrap_flags", bus.flags, 4'b0110);
    do_op(OP_DEC, 0, 1'b0);
    chk("dec_wrap_acc", bus.acc, 8'hFF);
    chk("dec_wrap_flags", bus.flags, 4'b1010);

    // Signed overflow.
    do_op(OP_LOAD, 8'h7F, 1'b0);
    do_op(OP_ADD, 8'h01, 1'b0);
    chk("add_ovf_acc", bus.acc, 8'h80);
    chk("add_ovf_flags", bus.flags, 4'b1001);
    do_op(OP_SUB, 8'h01, 1'b0);
    chk("sub_ovf_acc", bus.acc, 8'h7F);
    chk("sub_ovf_flags", bus.flags, 4'b0001);

    // Shifts and rotates with serial input.
    do_op(OP_LOAD, 8'h81, 1'b0);
    do_op(OP_SHL, 0, 1'b1);
    chk("shl_acc", bus.acc, 8'h03);
    chk("shl_flags", bus.flags, 4'b0010);
    do_op(OP_ROR, 0, 1'b0);
    chk("ror_acc", bus.acc, 8'h81);
    chk("ror_flags", bus.flags, 4'b1010);
    do_op(OP_SHR, 0, 1'b0);
    chk("shr_acc", bus.acc, 8'h40);
    chk("shr_flags", bus.flags, 4'b0010);

    // NOP keeps state but still completes.
    do_op(OP_NOP, 8'hAA, 1'b1);
    chk("nop_acc", bus.acc, 8'h40);

    // Multiply.
    do_op(OP_LOAD, 8'hC8, 1'b0);
    do_op(OP_MUL, 8'h0A, 1'b0);
    chk("mul_lo", bus.acc, 8'hD0);
    chk("mul_hi", bus.acc_hi, 8'h07);
    chk("mul_flags", bus.flags, 4'b1010);
    idle_cycle();

    // Reset in the middle of a multiply.
    do_op(OP_LOAD, 8'hFF, 1'b0);
    bus.valid   = 1'b1;
    bus.op      = OP_MUL;
    bus.operand = 8'hFF;
    @(posedge clk); #1;
    bus.valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("mid_mul_busy", bus.ready, 1'b0);
    async_reset();
    do_op(OP_LOAD, 8'h05, 1'b0);
    chk("post_rst_load", bus.acc, 8'h05);
    idle_cycle();

    // Randomized commands against the model.
    for (int i = 0; i < 150; i++) begin
      rop  = op_e'(4'($urandom_range(0, 15)));
      ropd = $urandom_range(0, MOD - 1);
      do_op(rop, ropd, 1'($urandom_range(0, 1)));
      if ($urandom_range(0, 7) == 0) idle_cycle();
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
